// File: rtl/frag_addr_gen.sv
// Fragment-to-framebuffer address stage: clips, addresses and pushes fragments
// into the writer FIFO, with a hardware frame clear sharing the same pipeline.
module frag_addr_gen #(
   parameter logic [31:0] FB_BASE   = 32'h0080_0000,
   parameter int unsigned FB_WIDTH  = 640,
   parameter int unsigned FB_HEIGHT = 480,
   parameter logic [31:0] CLEAR_Z   = 32'hFFFF_FFFF
) (
   input  logic        PLB_clk,
   input  logic        reset,
   input  logic        frag_valid,
   output logic        frag_ready,
   input  logic [9:0]  frag_x,
   input  logic [9:0]  frag_y,
   input  logic [23:0] frag_color,
   input  logic [31:0] frag_z,
   input  logic        clear_start,
   input  logic [23:0] clear_color,
   output logic        clear_busy,
   output logic [95:0] fifo_din,
   output logic        fifo_wr_en,
   input  logic        fifo_full,
   output logic [15:0] frag_dropped
);

   localparam int IW = 19;
   localparam logic [IW-1:0] LAST_IDX = IW'(FB_WIDTH * FB_HEIGHT - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t        state;
   logic          clr_inj;
   logic [IW-1:0] clr_idx;
   logic [23:0]   clr_color;

   logic          s1_valid;
   logic [IW-1:0] s1_idx;
   logic [23:0]   s1_color;
   logic [31:0]   s1_z;

   logic          s2_valid;
   logic [31:0]   s2_addr;
   logic [23:0]   s2_color;
   logic [31:0]   s2_z;

   logic          advance;
   logic          frag_acc;
   logic          in_range;
   logic          last_push;
   logic [IW-1:0] frag_idx;

   assign advance    = ~s2_valid | ~fifo_full;
   assign frag_ready = advance & ~clear_busy & ~clear_start & ~reset;
   assign frag_acc   = frag_valid & frag_ready;
   assign in_range   = (32'(frag_x) < FB_WIDTH) &&
                       (32'(frag_y) < FB_HEIGHT);
   assign frag_idx   = IW'(frag_y) * IW'(FB_WIDTH) + IW'(frag_x);

   assign fifo_wr_en = s2_valid & ~fifo_full;
   assign fifo_din   = {s2_z, 8'h00, s2_color, s2_addr};

   // Clear words are the youngest in flight, so the last one leaves
   // when injection has stopped and S1 is already empty.
   assign last_push  = clear_busy & ~clr_inj & ~s1_valid & fifo_wr_en;

   always_ff @(posedge PLB_clk) begin
      if (reset) begin
         state        <= IDLE;
         clear_busy   <= 1'b0;
         clr_inj      <= 1'b0;
         clr_idx      <= '0;
         clr_color    <= '0;
         frag_dropped <= '0;
      end else begin
         if (frag_acc && !in_range && frag_dropped != 16'hFFFF)
            frag_dropped <= frag_dropped + 16'd1;
         unique case (state)
            IDLE: begin
               if (clear_start) begin
                  state      <= CLEAR;
                  clear_busy <= 1'b1;
                  clr_inj    <= 1'b1;
                  clr_idx    <= '0;
                  clr_color  <= clear_color;
               end
            end
            CLEAR: begin
               if (clr_inj && advance) begin
                  if (clr_idx == LAST_IDX)
                     clr_inj <= 1'b0;
                  else
                     clr_idx <= clr_idx + 1'b1;
               end
               if (last_push) begin
                  state      <= IDLE;
                  clear_busy <= 1'b0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge PLB_clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_idx   <= '0;
         s1_color <= '0;
         s1_z     <= '0;
         s2_valid <= 1'b0;
         s2_addr  <= '0;
         s2_color <= '0;
         s2_z     <= '0;
      end else if (advance) begin
         if (state == CLEAR && clr_inj) begin
            s1_valid <= 1'b1;
            s1_idx   <= clr_idx;
            s1_color <= clr_color;
            s1_z     <= CLEAR_Z;
         end else if (frag_acc && in_range) begin
            s1_valid <= 1'b1;
            s1_idx   <= frag_idx;
            s1_color <= frag_color;
            s1_z     <= frag_z;
         end else begin
            s1_valid <= 1'b0;
         end
         s2_valid <= s1_valid;
         s2_addr  <= FB_BASE + {{(30-IW){1'b0}}, s1_idx, 2'b00};
         s2_color <= s1_color;
         s2_z     <= s1_z;
      end
   end

endmodule

// File: tb/tb_frag_addr_gen.sv
// Scoreboard bench for frag_addr_gen on a reduced frame so a full clear
// fits comfortably in simulation time.
module tb_frag_addr_gen;

   localparam int unsigned W = 40;
   localparam int unsigned H = 30;
   localparam int unsigned N = W * H;
   localparam logic [31:0] BASE = 32'h0080_0000;
   localparam logic [31:0] CZ = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        reset;
   logic        frag_valid;
   logic        frag_ready;
   logic [9:0]  frag_x;
   logic [9:0]  frag_y;
   logic [23:0] frag_color;
   logic [31:0] frag_z;
   logic        clear_start;
   logic [23:0] clear_color;
   logic        clear_busy;
   logic [95:0] fifo_din;
   logic        fifo_wr_en;
   logic        fifo_full;
   logic [15:0] frag_dropped;

   always #5 clk = ~clk;

   frag_addr_gen #(
      .FB_BASE(BASE), .FB_WIDTH(W), .FB_HEIGHT(H), .CLEAR_Z(CZ)
   ) dut (
      .PLB_clk(clk), .reset(reset),
      .frag_valid(frag_valid), .frag_ready(frag_ready),
      .frag_x(frag_x), .frag_y(frag_y),
      .frag_color(frag_color), .frag_z(frag_z),
      .clear_start(clear_start), .clear_color(clear_color),
      .clear_busy(clear_busy),
      .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en),
      .fifo_full(fifo_full), .frag_dropped(frag_dropped)
   );

   typedef struct {
      logic [95:0] w;
      bit          last;
   } ent_t;

   ent_t        sb[$];
   ent_t        me;
   int          nvec = 0;
   int          nfail = 0;
   bit          in_clear = 0;
   bit          chk_idle = 0;
   int          full_hold = 0;
   bit          rand_full = 0;
   int unsigned drops = 0;

   function automatic logic [95:0] word(input int unsigned idx,
                                        input logic [23:0] c,
                                        input logic [31:0] z);
      logic [31:0] a;
      a = BASE + 32'(idx) * 32'd4;
      return {z, 8'h00, c, a};
   endfunction

   task automatic chk(input string nm, input logic [95:0] act,
                      input logic [95:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_idle) begin
         chk("clear_busy_after_last", 96'(clear_busy), 96'(0));
         chk_idle = 0;
      end
      if (fifo_wr_en) begin
         if (sb.size() == 0) begin
            nvec++;
            nfail++;
            $display("FAIL unexpected_push: got %h, expected no push",
                     fifo_din);
         end else begin
            me = sb.pop_front();
            chk("push_word", fifo_din, me.w);
            if (me.last) begin
               chk("clear_busy_at_last", 96'(clear_busy), 96'(1));
               in_clear = 0;
               chk_idle = 1;
            end
         end
      end
   end

   task automatic cycle(output bit acc);
      @(negedge clk);
      acc = 0;
      if (!reset) begin
         chk("frag_dropped", 96'(frag_dropped), 96'(16'(drops)));
         if (clear_start || in_clear)
            chk("ready_low", 96'(frag_ready), 96'(0));
         if (clear_start) begin
            in_clear = 1;
            for (int i = 0; i < int'(N); i++)
               sb.push_back('{word(i, clear_color, CZ), i == int'(N) - 1});
         end else if (frag_valid && frag_ready) begin
            acc = 1;
            if (frag_x < W && frag_y < H)
               sb.push_back('{word(frag_y * W + frag_x, frag_color, frag_z),
                              1'b0});
            else if (drops < 16'hFFFF)
               drops++;
         end
      end
      @(posedge clk);
      #1;
      if (full_hold > 0) begin
         fifo_full = 1'b1;
         full_hold--;
      end else begin
         fifo_full = rand_full && ($urandom_range(0, 3) == 0);
      end
   endtask

   task automatic wait_accept(output int n);
      bit a;
      n = 0;
      do begin
         cycle(a);
         n++;
      end while (!a && n < 5000);
      if (!a) begin
         nvec++;
         nfail++;
         $display("FAIL accept_timeout: got no handshake, expected accept");
      end
      frag_valid = 1'b0;
   endtask

   task automatic send(input logic [9:0] x, input logic [9:0] y,
                       input logic [23:0] c, input logic [31:0] z,
                       output int n);
      frag_valid = 1'b1;
      frag_x = x;
      frag_y = y;
      frag_color = c;
      frag_z = z;
      wait_accept(n);
   endtask

   task automatic send_rand(input bit clip_ok);
      int n;
      send(10'($urandom_range(0, clip_ok ? W + 3 : W - 1)),
           10'($urandom_range(0, clip_ok ? H + 2 : H - 1)),
           24'($urandom), 32'($urandom), n);
   endtask

   task automatic clear(input logic [23:0] c);
      bit a;
      clear_start = 1'b1;
      clear_color = c;
      cycle(a);
      clear_start = 1'b0;
   endtask

   task automatic drain();
      bit a;
      int n = 0;
      while ((sb.size() != 0 || in_clear || chk_idle) && n < 10000) begin
         cycle(a);
         n++;
      end
      if (n >= 10000) begin
         nvec++;
         nfail++;
         $display("FAIL drain_timeout: got %0d pending, expected 0",
                  sb.size());
      end
   endtask

   initial begin
      int n;
      bit a;
      reset = 1'b1;
      frag_valid = 1'b0;
      frag_x = '0;
      frag_y = '0;
      frag_color = '0;
      frag_z = '0;
      clear_start = 1'b0;
      clear_color = '0;
      fifo_full = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_wr_en", 96'(fifo_wr_en), 96'(0));
      chk("rst_din", fifo_din, 96'(0));
      chk("rst_busy", 96'(clear_busy), 96'(0));
      chk("rst_dropped", 96'(frag_dropped), 96'(0));
      chk("rst_ready", 96'(frag_ready), 96'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;

      send(10'd3, 10'd2, 24'h123456, 32'd7, n);
      @(negedge clk);
      chk("latency_edge_n", 96'(fifo_wr_en), 96'(0));
      @(negedge clk);
      chk("latency_edge_n1", 96'(fifo_wr_en), 96'(1));
      @(posedge clk);
      #1;
      drain();

      for (int i = 0; i < 8; i++) begin
         if (i == 3) full_hold = 5;
         send_rand(1'b0);
      end
      drain();

      send(10'(W), 10'd0, 24'hABCDEF, 32'd1, n);
      chk("clip_x_ready", 96'(n), 96'(1));
      send(10'd0, 10'(H), 24'hABCDEF, 32'd2, n);
      chk("clip_y_ready", 96'(n), 96'(1));
      drain();
      chk("clip_count", 96'(frag_dropped), 96'(2));

      rand_full = 1;
      clear(24'h0000FF);
      drain();

      clear(24'($urandom));
      repeat (100) cycle(a);
      chk("busy_mid_clear", 96'(clear_busy), 96'(1));
      reset = 1'b1;
      cycle(a);
      sb.delete();
      in_clear = 0;
      drops = 0;
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_wr_en", 96'(fifo_wr_en), 96'(0));
      chk("post_rst_busy", 96'(clear_busy), 96'(0));
      @(posedge clk);
      #1;
      send_rand(1'b0);
      drain();

      frag_valid = 1'b1;
      frag_x = 10'd5;
      frag_y = 10'd6;
      frag_color = 24'h55AA55;
      frag_z = 32'h1234;
      clear_start = 1'b1;
      clear_color = 24'h00FF00;
      cycle(a);
      clear_start = 1'b0;
      wait_accept(n);
      drain();

      for (int i = 0; i < 300; i++) begin
         if (i == 150) clear(24'($urandom));
         if ($urandom_range(0, 3) == 0) cycle(a);
         else send_rand(1'b1);
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
